// File: rtl/cr_axis_chk_pkg.sv
// Shared types for the AXI-stream frame checker: error codes, tuser codes, frame types, read selects.
// Pure declarations, no latency.
// No flow control.
package cr_axis_chk_pkg;

    typedef enum logic [3:0] {
        ERR_NONE         = 4'd0,
        ERR_UNSTABLE     = 4'd1,
        ERR_BAD_USER     = 4'd2,
        ERR_SOT_IN_FRAME = 4'd3,
        ERR_NO_SOT       = 4'd4,
        ERR_TLAST        = 4'd5,
        ERR_STRB         = 4'd6,
        ERR_WDOG         = 4'd7
    } err_e;

    typedef enum logic [1:0] {
        TU_NONE = 2'd0,
        TU_SOT  = 2'd1,
        TU_EOT  = 2'd2,
        TU_MID  = 2'd3
    } tuser_e;

    typedef enum logic {
        ST_IDLE     = 1'b0,
        ST_IN_FRAME = 1'b1
    } state_e;

    typedef enum logic [1:0] {
        FT_DATA  = 2'd0,
        FT_STATS = 2'd1,
        FT_CQE   = 2'd2
    } ftype_e;

    localparam logic [7:0] FTYPE_STATS_BYTE = 8'h08;
    localparam logic [7:0] FTYPE_CQE_BYTE   = 8'h09;

    localparam logic [1:0] RD_FRAMES = 2'd0;
    localparam logic [1:0] RD_BEATS  = 2'd1;
    localparam logic [1:0] RD_ERRORS = 2'd2;
    localparam logic [1:0] RD_STATE  = 2'd3;

    function automatic ftype_e ftype_decode(input logic [7:0] b);
        if (b == FTYPE_CQE_BYTE)
            return FT_CQE;
        else if (b == FTYPE_STATS_BYTE)
            return FT_STATS;
        else
            return FT_DATA;
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/cr_axis_chk_sat_cnt.sv
// Saturating up-counter with synchronous clear; clear beats increment.
// Count visible one cycle after inc.
// No flow control; holds at all-ones instead of wrapping.
module cr_axis_chk_sat_cnt #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (inc && (cnt != '1))
            cnt <= cnt + W'(1);
    end

endmodule

// File: rtl/cr_axis_frame_checker.sv
// Passive multi-TID AXI-stream frame protocol monitor: framing, tlast, tstrb, stability, watchdog, counters.
// Error/frame pulses one cycle after the accepted beat; rd_data one cycle after rd_tid/rd_sel.
// Never drives backpressure; CR_AXIS_CHK_SIGNATURE_EN adds per-TID CRC-32 frame signatures.
module cr_axis_frame_checker
    import cr_axis_chk_pkg::*;
#(
    parameter int DATA_W      = 64,
    parameter int TID_W       = 1,
    parameter int USER_W      = 8,
    parameter int CNT_W       = 32,
    parameter int WDOG_CYCLES = 10000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                mon_tvalid,
    input  logic                mon_tready,
    input  logic [TID_W-1:0]    mon_tid,
    input  logic [DATA_W-1:0]   mon_tdata,
    input  logic [DATA_W/8-1:0] mon_tstrb,
    input  logic [USER_W-1:0]   mon_tuser,
    input  logic                mon_tlast,
    input  logic                clr,
    output logic                err_valid,
    output logic [3:0]          err_code,
    output logic [TID_W-1:0]    err_tid,
    output logic                frame_done,
    output logic [TID_W-1:0]    frame_tid,
    output logic [15:0]         frame_beats,
`ifdef CR_AXIS_CHK_SIGNATURE_EN
    output logic [31:0]         frame_sig,
`endif
    output logic                wdog_expired,
    input  logic [TID_W-1:0]    rd_tid,
    input  logic [1:0]          rd_sel,
    output logic [CNT_W-1:0]    rd_data
);

    localparam int STRB_W = DATA_W / 8;
    localparam int NUM_CH = 2 ** TID_W;
    localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);

    state_e      ctx_st [NUM_CH];
    ftype_e      ctx_ft [NUM_CH];
    logic [15:0] ctx_fb [NUM_CH];

    // Copy of a stalled beat, compared against the next cycle's bus.
    logic                hold_vld;
    logic [TID_W-1:0]    hold_tid;
    logic [DATA_W-1:0]   hold_tdata;
    logic [STRB_W-1:0]   hold_tstrb;
    logic [USER_W-1:0]   hold_tuser;
    logic                hold_tlast;

    logic [WDOG_W-1:0]   wdog_cnt;

    logic                beat;
    logic                busy;
    logic                unstable;
    logic                wdog_hit;
    tuser_e              code;
    state_e              cur_st, nxt_st;
    ftype_e              cur_ft, nxt_ft;
    logic [15:0]         cur_fb, nxt_fb, done_beats;
    logic                eot_done;
    logic                exp_tlast;
    logic [STRB_W-1:0]   strb_p1;
    logic                strb_bad;
    err_e                err_nxt;
    logic [TID_W-1:0]    err_tid_nxt;

    logic [CNT_W-1:0]    frames_cnt [NUM_CH];
    logic [CNT_W-1:0]    beats_cnt  [NUM_CH];
    logic [CNT_W-1:0]    errs_cnt   [NUM_CH];

`ifdef CR_AXIS_CHK_SIGNATURE_EN
    logic [31:0] ctx_crc [NUM_CH];
    logic [31:0] nxt_crc;

    // Reflected form of poly 0x04C11DB7, bytes in lane order, bits LSB-first.
    function automatic logic [31:0] crc_step(input logic [31:0]       c_in,
                                             input logic [DATA_W-1:0] d,
                                             input logic [STRB_W-1:0] s);
        logic [31:0] c;
        c = c_in;
        for (int b = 0; b < STRB_W; b++) begin
            if (s[b]) begin
                c = c ^ {24'd0, d[8*b +: 8]};
                for (int k = 0; k < 8; k++)
                    c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
            end
        end
        return c;
    endfunction
`endif

    assign beat = mon_tvalid & mon_tready;

    always_comb begin
        busy = 1'b0;
        for (int i = 0; i < NUM_CH; i++)
            busy = busy | (ctx_st[i] == ST_IN_FRAME);
    end

    assign wdog_hit = busy & ~beat & (wdog_cnt == WDOG_W'(WDOG_CYCLES - 1));

    always_comb begin
        code       = tuser_e'(mon_tuser[1:0]);
        cur_st     = ctx_st[mon_tid];
        cur_ft     = ctx_ft[mon_tid];
        cur_fb     = ctx_fb[mon_tid];
        nxt_st     = cur_st;
        nxt_ft     = cur_ft;
        nxt_fb     = cur_fb;
        done_beats = 16'd0;
        eot_done   = 1'b0;
`ifdef CR_AXIS_CHK_SIGNATURE_EN
        nxt_crc    = ctx_crc[mon_tid];
`endif

        unstable = hold_vld & (~mon_tvalid
                               | (mon_tid   != hold_tid)
                               | (mon_tdata != hold_tdata)
                               | (mon_tstrb != hold_tstrb)
                               | (mon_tuser != hold_tuser)
                               | (mon_tlast != hold_tlast));

        case (code)
            TU_SOT: begin
                nxt_st = ST_IN_FRAME;
                nxt_ft = ftype_decode(mon_tdata[7:0]);
                nxt_fb = 16'd1;
`ifdef CR_AXIS_CHK_SIGNATURE_EN
                nxt_crc = crc_step(32'hFFFF_FFFF, mon_tdata, mon_tstrb);
`endif
            end
            TU_EOT: begin
                if (cur_st == ST_IN_FRAME) begin
                    nxt_st     = ST_IDLE;
                    nxt_fb     = sat_inc16(cur_fb);
                    done_beats = sat_inc16(cur_fb);
                    eot_done   = 1'b1;
`ifdef CR_AXIS_CHK_SIGNATURE_EN
                    nxt_crc = crc_step(ctx_crc[mon_tid], mon_tdata, mon_tstrb);
`endif
                end
            end
            default: begin
                if (cur_st == ST_IN_FRAME) begin
                    nxt_fb = sat_inc16(cur_fb);
`ifdef CR_AXIS_CHK_SIGNATURE_EN
                    nxt_crc = crc_step(ctx_crc[mon_tid], mon_tdata, mon_tstrb);
`endif
                end
            end
        endcase

        exp_tlast = (code == TU_EOT) && (cur_st == ST_IN_FRAME) && (cur_ft == FT_CQE);
        strb_p1   = mon_tstrb + STRB_W'(1);
        strb_bad  = (mon_tstrb == '0) || ((mon_tstrb & strb_p1) != '0)
                    || ((code != TU_EOT) && (mon_tstrb != '1));

        err_nxt     = ERR_NONE;
        err_tid_nxt = '0;
        if (unstable) begin
            err_nxt     = ERR_UNSTABLE;
            err_tid_nxt = hold_tid;
        end else if (beat && ((mon_tuser >> 2) != '0)) begin
            err_nxt     = ERR_BAD_USER;
            err_tid_nxt = mon_tid;
        end else if (beat && (code == TU_SOT) && (cur_st == ST_IN_FRAME)) begin
            err_nxt     = ERR_SOT_IN_FRAME;
            err_tid_nxt = mon_tid;
        end else if (beat && ((code == TU_EOT) || (code == TU_MID)) && (cur_st == ST_IDLE)) begin
            err_nxt     = ERR_NO_SOT;
            err_tid_nxt = mon_tid;
        end else if (beat && (mon_tlast != exp_tlast)) begin
            err_nxt     = ERR_TLAST;
            err_tid_nxt = mon_tid;
        end else if (beat && strb_bad) begin
            err_nxt     = ERR_STRB;
            err_tid_nxt = mon_tid;
        end else if (wdog_hit) begin
            err_nxt     = ERR_WDOG;
            err_tid_nxt = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_valid    <= 1'b0;
            err_code     <= 4'd0;
            err_tid      <= '0;
            frame_done   <= 1'b0;
            frame_tid    <= '0;
            frame_beats  <= 16'd0;
            wdog_expired <= 1'b0;
            wdog_cnt     <= '0;
            hold_vld     <= 1'b0;
            hold_tid     <= '0;
            hold_tdata   <= '0;
            hold_tstrb   <= '0;
            hold_tuser   <= '0;
            hold_tlast   <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                ctx_st[i] <= ST_IDLE;
                ctx_ft[i] <= FT_DATA;
                ctx_fb[i] <= 16'd0;
`ifdef CR_AXIS_CHK_SIGNATURE_EN
                ctx_crc[i] <= 32'd0;
`endif
            end
`ifdef CR_AXIS_CHK_SIGNATURE_EN
            frame_sig <= 32'd0;
`endif
        end else if (clr) begin
            err_valid    <= 1'b0;
            err_code     <= 4'd0;
            err_tid      <= '0;
            frame_done   <= 1'b0;
            frame_tid    <= '0;
            frame_beats  <= 16'd0;
            wdog_expired <= 1'b0;
            wdog_cnt     <= '0;
            hold_vld     <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                ctx_st[i] <= ST_IDLE;
                ctx_ft[i] <= FT_DATA;
                ctx_fb[i] <= 16'd0;
`ifdef CR_AXIS_CHK_SIGNATURE_EN
                ctx_crc[i] <= 32'd0;
`endif
            end
`ifdef CR_AXIS_CHK_SIGNATURE_EN
            frame_sig <= 32'd0;
`endif
        end else begin
            err_valid   <= (err_nxt != ERR_NONE);
            err_code    <= err_nxt;
            err_tid     <= err_tid_nxt;
            frame_done  <= beat & eot_done;
            frame_tid   <= (beat & eot_done) ? mon_tid : '0;
            frame_beats <= (beat & eot_done) ? done_beats : 16'd0;
`ifdef CR_AXIS_CHK_SIGNATURE_EN
            frame_sig   <= (beat & eot_done) ? ~nxt_crc : 32'd0;
`endif
            if (wdog_hit)
                wdog_expired <= 1'b1;

            if (beat || !busy)
                wdog_cnt <= '0;
            else if (wdog_cnt != WDOG_W'(WDOG_CYCLES))
                wdog_cnt <= wdog_cnt + WDOG_W'(1);

            hold_vld   <= mon_tvalid & ~mon_tready;
            hold_tid   <= mon_tid;
            hold_tdata <= mon_tdata;
            hold_tstrb <= mon_tstrb;
            hold_tuser <= mon_tuser;
            hold_tlast <= mon_tlast;

            if (beat) begin
                ctx_st[mon_tid] <= nxt_st;
                ctx_ft[mon_tid] <= nxt_ft;
                ctx_fb[mon_tid] <= nxt_fb;
`ifdef CR_AXIS_CHK_SIGNATURE_EN
                ctx_crc[mon_tid] <= nxt_crc;
`endif
            end
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_cnt
        logic sel;
        assign sel = (mon_tid == TID_W'(g));

        cr_axis_chk_sat_cnt #(.W(CNT_W)) u_frames (
            .clk   (clk),
            .rst_n (rst_n),
            .clr   (clr),
            .inc   (beat & eot_done & sel),
            .cnt   (frames_cnt[g])
        );

        cr_axis_chk_sat_cnt #(.W(CNT_W)) u_beats (
            .clk   (clk),
            .rst_n (rst_n),
            .clr   (clr),
            .inc   (beat & sel),
            .cnt   (beats_cnt[g])
        );

        cr_axis_chk_sat_cnt #(.W(CNT_W)) u_errs (
            .clk   (clk),
            .rst_n (rst_n),
            .clr   (clr),
            .inc   ((err_nxt != ERR_NONE) && (err_tid_nxt == TID_W'(g))),
            .cnt   (errs_cnt[g])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else begin
            case (rd_sel)
                RD_FRAMES: rd_data <= frames_cnt[rd_tid];
                RD_BEATS:  rd_data <= beats_cnt[rd_tid];
                RD_ERRORS: rd_data <= errs_cnt[rd_tid];
`ifdef CR_AXIS_CHK_SIGNATURE_EN
                default:   rd_data <= CNT_W'(~ctx_crc[rd_tid]);
`else
                default:   rd_data <= CNT_W'({ctx_st[rd_tid], ctx_ft[rd_tid]});
`endif
            endcase
        end
    end

endmodule

// File: tb/tb_cr_axis_frame_checker.sv
// Directed bench for cr_axis_frame_checker: framing, error priorities, stability, watchdog, clear.
// Outputs sampled 1 time unit after the active edge.
module tb_cr_axis_frame_checker;

    logic        clk;
    logic        rst_n;
    logic        mon_tvalid;
    logic        mon_tready;
    logic [0:0]  mon_tid;
    logic [63:0] mon_tdata;
    logic [7:0]  mon_tstrb;
    logic [7:0]  mon_tuser;
    logic        mon_tlast;
    logic        clr;
    logic        err_valid;
    logic [3:0]  err_code;
    logic [0:0]  err_tid;
    logic        frame_done;
    logic [0:0]  frame_tid;
    logic [15:0] frame_beats;
`ifdef CR_AXIS_CHK_SIGNATURE_EN
    logic [31:0] frame_sig;
`endif
    logic        wdog_expired;
    logic [0:0]  rd_tid;
    logic [1:0]  rd_sel;
    logic [31:0] rd_data;

    int n_cmp = 0;
    int n_bad = 0;
    int wcyc;

    cr_axis_frame_checker #(
        .DATA_W(64), .TID_W(1), .USER_W(8), .CNT_W(32), .WDOG_CYCLES(10000)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .mon_tvalid   (mon_tvalid),
        .mon_tready   (mon_tready),
        .mon_tid      (mon_tid),
        .mon_tdata    (mon_tdata),
        .mon_tstrb    (mon_tstrb),
        .mon_tuser    (mon_tuser),
        .mon_tlast    (mon_tlast),
        .clr          (clr),
        .err_valid    (err_valid),
        .err_code     (err_code),
        .err_tid      (err_tid),
        .frame_done   (frame_done),
        .frame_tid    (frame_tid),
        .frame_beats  (frame_beats),
`ifdef CR_AXIS_CHK_SIGNATURE_EN
        .frame_sig    (frame_sig),
`endif
        .wdog_expired (wdog_expired),
        .rd_tid       (rd_tid),
        .rd_sel       (rd_sel),
        .rd_data      (rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic t, input logic [63:0] d, input logic [7:0] s,
                        input logic [7:0] u, input logic l);
        mon_tid    = t;
        mon_tdata  = d;
        mon_tstrb  = s;
        mon_tuser  = u;
        mon_tlast  = l;
        mon_tvalid = 1'b1;
        mon_tready = 1'b1;
        tick();
        mon_tvalid = 1'b0;
    endtask

    task automatic rd(input logic t, input logic [1:0] sel);
        rd_tid = t;
        rd_sel = sel;
        tick();
    endtask

    initial begin
        rst_n = 1'b0; clr = 1'b0;
        mon_tvalid = 1'b0; mon_tready = 1'b1; mon_tid = '0; mon_tdata = '0;
        mon_tstrb = 8'hFF; mon_tuser = '0; mon_tlast = 1'b0;
        rd_tid = '0; rd_sel = 2'd0;
        repeat (3) tick();
        chk("rst_err_valid", err_valid, 0);
        chk("rst_err_code", err_code, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_wdog", wdog_expired, 0);
        chk("rst_rd_data", rd_data, 0);
        rst_n = 1'b1;
        tick();

        // CQE frame on TID0: SoT, 2 mids, EoT with tlast
        send(0, 64'h09, 8'hFF, 8'd1, 0);
        chk("cqe_sot_noerr", err_valid, 0);
        send(0, 64'h1111, 8'hFF, 8'd3, 0);
        send(0, 64'h2222, 8'hFF, 8'd3, 0);
        send(0, 64'h3333, 8'hFF, 8'd2, 1);
        chk("cqe_done", frame_done, 1);
        chk("cqe_done_tid", frame_tid, 0);
        chk("cqe_beats", frame_beats, 4);
        chk("cqe_eot_noerr", err_valid, 0);
        rd(0, 2'd0); chk("rd_frames0", rd_data, 1);
        rd(0, 2'd1); chk("rd_beats0", rd_data, 4);
        rd(0, 2'd2); chk("rd_errs0", rd_data, 0);
`ifndef CR_AXIS_CHK_SIGNATURE_EN
        rd(0, 2'd3); chk("rd_state0", rd_data, 32'h2);
`endif

        // CQE EoT without tlast
        send(0, 64'h09, 8'hFF, 8'd1, 0);
        send(0, 64'h0, 8'hFF, 8'd2, 0);
        chk("tlast_err_valid", err_valid, 1);
        chk("tlast_err_code", err_code, 5);
        chk("tlast_err_tid", err_tid, 0);
        chk("tlast_frame_done", frame_done, 1);
        chk("tlast_beats", frame_beats, 2);

        // SoT, SoT, EoT on TID1
        send(1, 64'h11, 8'hFF, 8'd1, 0);
        chk("sot1_noerr", err_valid, 0);
        send(1, 64'h11, 8'hFF, 8'd1, 0);
        chk("sotsot_code", err_code, 3);
        chk("sotsot_tid", err_tid, 1);
        send(1, 64'h0, 8'hFF, 8'd2, 0);
        chk("sotsot_done", frame_done, 1);
        chk("sotsot_done_tid", frame_tid, 1);
        chk("sotsot_beats", frame_beats, 2);
        chk("sotsot_eot_noerr", err_valid, 0);
        rd(1, 2'd2); chk("rd_errs1", rd_data, 1);

        // Middle while idle, unframed while idle
        send(1, 64'h0, 8'hFF, 8'd3, 0);
        chk("nosot_code", err_code, 4);
        chk("nosot_tid", err_tid, 1);
        send(1, 64'h0, 8'hFF, 8'd0, 0);
        chk("unframed_noerr", err_valid, 0);

        // Strobe violations: partial on SoT, non-contiguous on EoT
        send(0, 64'h0, 8'h0F, 8'd1, 0);
        chk("strb_sot_code", err_code, 6);
        send(0, 64'h0, 8'h05, 8'd2, 0);
        chk("strb_eot_code", err_code, 6);
        chk("strb_eot_done", frame_done, 1);

        // Nonzero upper tuser bits outrank everything else on the beat
        send(0, 64'h0, 8'hFF, 8'h05, 0);
        chk("baduser_code", err_code, 2);
        send(0, 64'h0, 8'hFF, 8'd2, 0);
        chk("baduser_close", frame_done, 1);

        // Stalled beat changes tdata
        mon_tid = 0; mon_tdata = 64'hA5; mon_tstrb = 8'hFF; mon_tuser = 8'd0; mon_tlast = 0;
        mon_tvalid = 1'b1; mon_tready = 1'b0;
        tick();
        chk("stall_noerr", err_valid, 0);
        mon_tdata = 64'h5A;
        tick();
        chk("unstable_valid", err_valid, 1);
        chk("unstable_code", err_code, 1);
        chk("unstable_tid", err_tid, 0);
        mon_tready = 1'b1;
        tick();
        chk("stable_accept_noerr", err_valid, 0);
        mon_tvalid = 1'b0;

`ifdef CR_AXIS_CHK_SIGNATURE_EN
        send(0, 64'h3837363534333231, 8'hFF, 8'd1, 0);
        send(0, 64'h39, 8'h01, 8'd2, 0);
        chk("sig_done", frame_done, 1);
        chk("sig_value", frame_sig, 32'hCBF43926);
`endif

        // Watchdog: SoT then idle
        send(0, 64'h0, 8'hFF, 8'd1, 0);
        wcyc = 0;
        for (int i = 0; i < 10100; i++) begin
            tick();
            wcyc++;
            if (err_valid) break;
        end
        chk("wdog_cycles", wcyc, 10000);
        chk("wdog_code", err_code, 7);
        chk("wdog_tid", err_tid, 0);
        chk("wdog_expired", wdog_expired, 1);
        tick();
        chk("wdog_sticky", wdog_expired, 1);
        chk("wdog_single_pulse", err_valid, 0);

        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("clr_wdog", wdog_expired, 0);
        chk("clr_err_valid", err_valid, 0);
        rd(0, 2'd0); chk("clr_frames0", rd_data, 0);
        rd(0, 2'd2); chk("clr_errs0", rd_data, 0);

        // clr coincident with a SoT: beat is dropped
        clr = 1'b1;
        mon_tid = 1; mon_tdata = 64'h0; mon_tstrb = 8'hFF; mon_tuser = 8'd1; mon_tlast = 0;
        mon_tvalid = 1'b1; mon_tready = 1'b1;
        tick();
        clr = 1'b0; mon_tvalid = 1'b0;
        chk("clrbeat_noerr", err_valid, 0);
        rd(1, 2'd1); chk("clrbeat_beats1", rd_data, 0);
        send(1, 64'h0, 8'hFF, 8'd2, 0);
        chk("clrbeat_nosot", err_code, 4);
        chk("clrbeat_no_done", frame_done, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
